// File: rtl/serial_subtractor.sv
// Purpose: multi-cycle a - b - bin, DIGIT bits per clock, LSB slice first, with borrow/zero/ovf flags.
// Latency: NSTEPS = WIDTH/DIGIT cycles from the accept edge to out_valid.
// Backpressure: out_ready low holds DONE with all outputs constant; in_ready is high only in IDLE.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] difference,
  output logic             borrow,
  output logic             zero,
  output logic             ovf
);

  localparam int NSTEPS = WIDTH / DIGIT;
  localparam int CW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;

  // Refuse to build with a slice size that does not tile the operand.
  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_subtractor: WIDTH must be >= 1 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             breg;
  logic [CW-1:0]    cnt;
  logic             last_step;
  int               base;
  logic [DIGIT:0]   slice_res;
  logic [WIDTH-1:0] diff_nxt;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign last_step = (cnt == CW'(NSTEPS - 1));
  assign base      = int'(cnt) * DIGIT;

  // One digit of the ripple: the extra top bit of the (DIGIT+1)-bit result is the borrow out.
  always_comb begin
    slice_res = {1'b0, a_r[base +: DIGIT]} - {1'b0, b_r[base +: DIGIT]} - {{DIGIT{1'b0}}, breg};
    diff_nxt  = difference;
    diff_nxt[base +: DIGIT] = slice_res[DIGIT-1:0];
  end

  // Next-state decode: accept in IDLE, step through NSTEPS slices, hold result until consumed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = CALC;
      CALC:    if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operand capture, slice-by-slice result write and flag update on the final slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r        <= '0;
      b_r        <= '0;
      breg       <= 1'b0;
      cnt        <= '0;
      difference <= '0;
      borrow     <= 1'b0;
      zero       <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r  <= a;
            b_r  <= b;
            breg <= bin;
            cnt  <= '0;
          end
        end
        CALC: begin
          difference <= diff_nxt;
          breg       <= slice_res[DIGIT];
          cnt        <= cnt + 1'b1;
          if (last_step) begin
            borrow <= slice_res[DIGIT];
            zero   <= (diff_nxt == '0);
            ovf    <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (diff_nxt[WIDTH-1] != a_r[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Purpose: randomized and directed check of serial_subtractor against an arithmetic reference.
// Latency: checks NSTEPS-cycle latency on three configurations (8/1, 16/4, 8/8).
// Backpressure: holds out_ready low in DONE and confirms results stay put and new operands wait.
module tb_serial_subtractor;

  logic        clk;
  logic        rst_n;
  logic [2:0]  in_valid;
  logic [2:0]  out_ready;
  logic [15:0] a_i;
  logic [15:0] b_i;
  logic        bin_i;
  wire  [2:0]  in_ready;
  wire  [2:0]  out_valid;
  wire  [2:0]  brw;
  wire  [2:0]  zr;
  wire  [2:0]  ov;
  wire  [7:0]  d0;
  wire  [15:0] d1;
  wire  [7:0]  d2;

  int total = 0;
  int bad   = 0;

  localparam int W [3] = '{8, 16, 8};
  localparam int N [3] = '{8, 4, 1};

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a_i[7:0]), .b(b_i[7:0]), .bin(bin_i), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .difference(d0), .borrow(brw[0]), .zero(zr[0]), .ovf(ov[0]));

  serial_subtractor #(.WIDTH(16), .DIGIT(4)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a_i), .b(b_i), .bin(bin_i), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .difference(d1), .borrow(brw[1]), .zero(zr[1]), .ovf(ov[1]));

  serial_subtractor #(.WIDTH(8), .DIGIT(8)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a_i[7:0]), .b(b_i[7:0]), .bin(bin_i), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .difference(d2), .borrow(brw[2]), .zero(zr[2]), .ovf(ov[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] dif(input int s);
    case (s)
      0:       return {8'h00, d0};
      1:       return d1;
      default: return {8'h00, d2};
    endcase
  endfunction

  // Reference: plain integer arithmetic on the operands truncated to w bits.
  task automatic model(input int w, input logic [15:0] av, input logic [15:0] bv, input logic bi,
                       output logic [15:0] d, output logic br, output logic z, output logic o);
    longint m, aa, bb, full;
    m    = 64'sd1 << w;
    aa   = longint'(av) & (m - 1);
    bb   = longint'(bv) & (m - 1);
    full = aa - bb - longint'(bi);
    d    = 16'(full & (m - 1));
    br   = (aa < bb + longint'(bi));
    z    = (d == 16'h0);
    o    = (aa[w-1] != bb[w-1]) && (d[w-1] != aa[w-1]);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for out_valid after the accept edge, then check latency, result and release.
  task automatic wait_check(input int sel, input logic [15:0] av, input logic [15:0] bv,
                            input logic bi, input logic hold, input string tag);
    logic [15:0] ed;
    logic        eb, ez, eo;
    int          cyc;
    model(W[sel], av, bv, bi, ed, eb, ez, eo);
    cyc = 0;
    while (!out_valid[sel] && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, ".lat"}, cyc, N[sel]);
    chk({tag, ".diff"}, dif(sel), ed);
    chk({tag, ".borrow"}, brw[sel], eb);
    chk({tag, ".zero"}, zr[sel], ez);
    chk({tag, ".ovf"}, ov[sel], eo);
    chk({tag, ".rdy_done"}, in_ready[sel], 0);
    if (!hold) begin
      @(posedge clk); #1;
      chk({tag, ".vld_drop"}, out_valid[sel], 0);
      chk({tag, ".rdy_back"}, in_ready[sel], 1);
    end
  endtask

  // Present operands for one cycle, then scramble the inputs while the block computes.
  task automatic do_op(input int sel, input logic [15:0] av, input logic [15:0] bv,
                       input logic bi, input logic hold, input string tag);
    a_i = av; b_i = bv; bin_i = bi;
    in_valid[sel]  = 1'b1;
    out_ready[sel] = !hold;
    chk({tag, ".rdy_idle"}, in_ready[sel], 1);
    @(posedge clk); #1;
    in_valid[sel] = 1'b0;
    a_i = 16'($urandom); b_i = 16'($urandom); bin_i = 1'($urandom);
    chk({tag, ".rdy_calc"}, in_ready[sel], 0);
    wait_check(sel, av, bv, bi, hold, tag);
  endtask

  initial begin
    logic [15:0] ed, ra, rb;
    logic        eb, ez, eo, rbi;

    rst_n = 1'b0; in_valid = '0; out_ready = '0; a_i = '0; b_i = '0; bin_i = 1'b0;
    #12;
    chk("rst.diff", {8'h0, d0}, 0);
    chk("rst.borrow", brw[0], 0);
    chk("rst.zero", zr[0], 0);
    chk("rst.ovf", ov[0], 0);
    chk("rst.vld", out_valid, 0);
    chk("rst.rdy", in_ready, 3'b111);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases on the bit-serial configuration.
    do_op(0, 16'h05, 16'h03, 1'b0, 1'b0, "d05_03");
    do_op(0, 16'h03, 16'h05, 1'b0, 1'b0, "d03_05");
    do_op(0, 16'h00, 16'h00, 1'b1, 1'b0, "d00_bin");
    do_op(0, 16'h10, 16'h10, 1'b0, 1'b0, "d10_10");
    do_op(0, 16'h80, 16'h01, 1'b0, 1'b0, "d80_01");
    do_op(0, 16'h7F, 16'hFF, 1'b0, 1'b0, "d7f_ff");

    // Backpressure: result held in DONE while new operands are already offered.
    do_op(0, 16'h5A, 16'h33, 1'b0, 1'b1, "bp");
    model(8, 16'h5A, 16'h33, 1'b0, ed, eb, ez, eo);
    a_i = 16'h21; b_i = 16'h47; bin_i = 1'b1; in_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp.hold_rdy", in_ready[0], 0);
      chk("bp.hold_vld", out_valid[0], 1);
      chk("bp.hold_diff", dif(0), ed);
      chk("bp.hold_borrow", brw[0], eb);
    end
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp.vld_drop", out_valid[0], 0);
    chk("bp.rdy_rise", in_ready[0], 1);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    chk("bp.accepted", in_ready[0], 0);
    wait_check(0, 16'h21, 16'h47, 1'b1, 1'b0, "bp_new");

    // Reset during the 4th CALC cycle aborts everything asynchronously.
    a_i = 16'hC3; b_i = 16'h5E; bin_i = 1'b1; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst.diff", dif(0), 0);
    chk("mrst.borrow", brw[0], 0);
    chk("mrst.zero", zr[0], 0);
    chk("mrst.ovf", ov[0], 0);
    chk("mrst.vld", out_valid[0], 0);
    chk("mrst.rdy", in_ready[0], 1);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mrst.no_vld", out_valid[0], 0);
    do_op(0, 16'h09, 16'h04, 1'b0, 1'b0, "post_rst");

    // Wide, 4-bit digits: borrow must ripple across slice boundaries.
    do_op(1, 16'h1000, 16'h0001, 1'b0, 1'b0, "w16_1000");
    do_op(1, 16'h0000, 16'h0000, 1'b1, 1'b0, "w16_bin");
    // Single-cycle configuration.
    do_op(2, 16'h80, 16'h01, 1'b0, 1'b0, "w8d8");

    // Random operands on all three configurations.
    for (int i = 0; i < 30; i++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rbi = 1'($urandom);
      do_op(i % 3, ra, rb, rbi, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Parametrised multi-cycle subtractor that computes `a - b - bin` on WIDTH-bit unsigned operands, DIGIT bits per clock, LSB slice first. It rippled the borrow through a registered chain. The block has a valid/ready handshake on both input and result. It also reports borrow-out, zero and signed-overflow flags. It is the arithmetic building block for datapaths that trade latency for area.

## Interface
- WIDTH, 8, operand and result width in bits; must be ≥1.
- DIGIT, 1, bits processed per CALC cycle; WIDTH % DIGIT must be 0, otherwise elaboration fails.
- NSTEPS, WIDTH/DIGIT, derived local value; number of CALC cycles.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and bin are valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- bin  in  1  borrow in.
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  consumer accepts result.
- difference  out  WIDTH  (a - b - bin) mod 2^WIDTH.
- borrow  out  1  1 iff a < b + bin (unsigned).
- zero  out  1  difference == 0.
- ovf  out  1  signed overflow: a[MSB] != b[MSB] and difference[MSB] != a[MSB].

## Operation
- Reset (async, rst_n=0):
  - State goes to IDLE. The step counter, operand registers and borrow register clear.
  - difference=0, borrow=0, zero=0, ovf=0, out_valid=0, in_ready=1 (in_ready is combinational from state).
- The block has three states:
  - IDLE:
    - in_ready=1.
    - On in_valid&&in_ready at an edge, latch a, b and bin. The borrow register takes bin. Clear the counter to 0. Go to CALC.
  - CALC:
    - in_ready=0.
    - At each edge, take slice k = counter: {bnew, d} = a[k*DIGIT +: DIGIT] - b[k*DIGIT +: DIGIT] - breg.
    - Write d into difference[k*DIGIT +: DIGIT], set breg=bnew, and increment the counter.
    - At the edge processing k=NSTEPS-1: set borrow=bnew, compute zero and ovf from the final difference, and go to DONE.
  - DONE:
    - out_valid=1. All outputs are held stable.
    - On out_ready at an edge, go to IDLE.
- in_valid outside IDLE is ignored and the operands are not sampled. Input changes during CALC have no effect.
- difference, borrow, zero and ovf keep their last result after DONE. They are meaningful only while out_valid=1. difference is overwritten slice by slice in the next CALC.
- Reset mid-CALC or mid-DONE aborts the operation immediately. No partial result is ever flagged valid.

## Timing
- Accept edge E0. CALC occupies edges E1..E_NSTEPS. out_valid rises after edge E_NSTEPS, giving a latency of NSTEPS cycles from accept to out_valid.
- With WIDTH=8 and DIGIT=1, latency is 8. With DIGIT=4, it is 2. With DIGIT=WIDTH, it is 1.
- If out_ready is already high when DONE is entered, out_valid is high for exactly 1 cycle. in_ready rises in the following cycle.
- There is no same-cycle result/accept overlap. Minimum issue interval is NSTEPS+2 cycles.
- out_ready low holds DONE indefinitely, with outputs constant.
- All outputs are registered except in_ready and out_valid, which are decoded directly from the state register.

## Test plan
- Default params, a=0x05, b=0x03, bin=0 → after 8 cycles: out_valid=1, difference=0x02, borrow=0, zero=0, ovf=0.
- a=0x03, b=0x05, bin=0 → difference=0xFE, borrow=1, ovf=0. Then a=0x00, b=0x00, bin=1 → difference=0xFF, borrow=1. Then a=0x10, b=0x10, bin=0 → difference=0x00, zero=1, borrow=0.
- a=0x80, b=0x01 → difference=0x7F, borrow=0, ovf=1. Then a=0x7F, b=0xFF → difference=0x80, borrow=1, ovf=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands. Required: in_ready=0, and the result is unchanged for all 5 cycles.
  - Raise out_ready. Required: out_valid drops next cycle, then in_ready=1, and the new operands are accepted only then.
- Reset at the 4th CALC cycle → all outputs 0 and in_ready=1 asynchronously. After release, a=0x09, b=0x04 → difference=0x05 after 8 cycles.
- WIDTH=16, DIGIT=4, a=0x1000, b=0x0001 → out_valid after 4 cycles, difference=0x0FFF, borrow=0. Check that the borrow crosses slice boundaries correctly.
